dcache_responder: RTL and testbench



---
 rtl/dcache_responder.sv | 134 +++++++++++++
 tb/tb_dcache_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with a req/ack
// backing-memory port and saturating hit/miss profiling counters.
module dcache_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  flush,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  cache_valid,
  output logic                  cache_hit,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_MISS_RD, S_WR_THRU} state_e;

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  cache_valid_q, cache_hit_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0] idx_in, idx_l;
  logic [TAG_W-1:0] tag_in, tag_l;
  logic             lookup_hit, accept, done, hit_inc, miss_inc;

  assign idx_in     = addr[IDX_W+1:2];
  assign tag_in     = addr[ADDR_WIDTH-1:IDX_W+2];
  assign idx_l      = addr_q[IDX_W+1:2];
  assign tag_l      = addr_q[ADDR_WIDTH-1:IDX_W+2];
  assign lookup_hit = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign accept     = req && (state_q == S_IDLE) && !flush;
  // mem_ack only means something while a request is outstanding
  assign done       = (state_q != S_IDLE) && mem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (we)               state_d = S_WR_THRU;
        else if (!lookup_hit) state_d = S_MISS_RD;
      end
      S_MISS_RD, S_WR_THRU: if (mem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    mem_req   = (state_q != S_IDLE);
    mem_we    = (state_q == S_WR_THRU);
    mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata = mem_we ? wdata_q : '0;
    hit_inc   = (accept && !we && lookup_hit) || (done && mem_we && hit_q);
    miss_inc  = done && !(mem_we && hit_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      hit_q         <= 1'b0;
      read_data_q   <= '0;
      cache_valid_q <= 1'b0;
      cache_hit_q   <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cache_valid_q <= 1'b0;
      cache_hit_q   <= 1'b0;
      if (state_q == S_IDLE && flush) valid_q <= '0;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= write_data;
        hit_q   <= lookup_hit;
        if (!we && lookup_hit) begin
          read_data_q   <= data_q[idx_in];
          cache_valid_q <= 1'b1;
          cache_hit_q   <= 1'b1;
        end
      end
      if (done) begin
        cache_valid_q <= 1'b1;
        cache_hit_q   <= mem_we && hit_q;
        if (!mem_we) begin
          valid_q[idx_l] <= 1'b1;
          read_data_q    <= mem_rdata;
        end
      end
      if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (accept && we && lookup_hit) data_q[idx_in] <= write_data;
    if (done && !mem_we) begin
      tag_q[idx_l]  <= tag_l;
      data_q[idx_l] <= mem_rdata;
    end
  end

  assign read_data   = read_data_q;
  assign cache_valid = cache_valid_q;
  assign cache_hit   = cache_hit_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Randomized + directed bench for dcache_responder against a line-level cache
// and backing-memory model kept in plain arrays.
module tb_dcache_responder;
  localparam int AW = 32, DW = 32, NL = 16, CW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req = 1'b0, we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] addr = '0, mem_addr;
  logic [DW-1:0] write_data = '0, mem_rdata = '0, read_data, mem_wdata;
  logic          ready, cache_valid, cache_hit, mem_req, mem_we;
  logic [CW-1:0] hit_count, miss_count;

  dcache_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LINES(NL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .write_data(write_data),
    .flush(flush), .ready(ready), .read_data(read_data), .cache_valid(cache_valid),
    .cache_hit(cache_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: line table, backing memory, counters, last load result
  bit          m_valid [NL];
  logic [31:0] m_waddr [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] mem [int unsigned];
  int          m_hits = 0, m_misses = 0;
  logic [31:0] m_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic int sat_inc(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    m_hits = 0; m_misses = 0; m_rd = '0;
  endtask

  // One core access, started on a negedge with the cache idle; d = mem_req cycles before ack.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] wd, input int d);
    logic [31:0] wa;
    int          li;
    bit          hit;
    wa  = a & 32'hFFFF_FFFC;
    li  = (a >> 2) % NL;
    hit = m_valid[li] && (m_waddr[li] == wa);
    chk("ready_before_req", {31'b0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; write_data = wd;
    @(negedge clk);
    req = 1'b0; write_data = $urandom;
    if (!w && hit) begin
      m_rd = m_data[li]; m_hits = sat_inc(m_hits);
      chk("ld_hit_valid", {30'b0, cache_valid, cache_hit}, 32'd3);
      chk("ld_hit_no_memreq", {31'b0, mem_req}, 32'd0);
    end else begin
      for (int k = 1; k <= d; k++) begin
        chk("memreq_held", {30'b0, mem_req, mem_we}, {30'b0, 1'b1, w});
        chk("mem_addr", mem_addr, wa);
        if (w) chk("mem_wdata", mem_wdata, wd);
        chk("no_resp_during_req", {31'b0, cache_valid}, 32'd0);
        if (k == d) begin mem_ack = 1'b1; mem_rdata = w ? $urandom : mem_rd(wa); end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      if (w) begin
        mem[wa] = wd;
        if (hit) begin m_data[li] = wd; m_hits = sat_inc(m_hits); end
        else m_misses = sat_inc(m_misses);
      end else begin
        m_valid[li] = 1; m_waddr[li] = wa; m_data[li] = mem[wa]; m_rd = mem[wa];
        m_misses = sat_inc(m_misses);
      end
      chk("resp_valid_hit", {30'b0, cache_valid, cache_hit}, {30'b0, 1'b1, hit && w});
      chk("ready_after_resp", {30'b0, ready, mem_req}, 32'd2);
    end
    chk("read_data", read_data, m_rd);
    chk("hit_count", {28'b0, hit_count}, m_hits);
    chk("miss_count", {28'b0, miss_count}, m_misses);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_outs", {27'b0, cache_valid, cache_hit, mem_req, mem_we, 1'b0}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_counts", {hit_count, miss_count}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed scenarios
    mem[32'h100] = 32'hDEADBEEF;
    access(0, 32'h100, 0, 3);
    chk("first_miss_data", read_data, 32'hDEADBEEF);
    access(0, 32'h100, 0, 1);
    chk("rehit_flag", {31'b0, cache_hit}, 32'd1);
    access(1, 32'h100, 32'h12345678, 2);
    access(0, 32'h100, 0, 1);
    chk("store_hit_reload", read_data, 32'h12345678);
    access(0, 32'h140, 0, 1);
    access(0, 32'h100, 0, 2);
    chk("evicted_miss_hit", {31'b0, cache_hit}, 32'd0);

    // flush wins over a simultaneous request
    flush = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h100;
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    chk("flush_ready", {29'b0, ready, mem_req, cache_valid}, 32'd4);
    access(0, 32'h140, 0, 1);

    // reset in the middle of a miss
    req = 1'b1; we = 1'b0; addr = 32'h208;
    @(negedge clk);
    req = 1'b0;
    chk("pre_rst_memreq", {31'b0, mem_req}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_memreq", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_counts", {hit_count, miss_count}, 32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_no_resp", {31'b0, cache_valid}, 32'd0);
    access(0, 32'h208, 0, 1);

    // Randomized accesses over a small, conflict-heavy address pool
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      access($urandom_range(0, 3) == 0, a, $urandom, $urandom_range(1, 3));
    end

    // Counter saturation on back-to-back hits
    access(0, 32'h3C0, 0, 1);
    for (int n = 0; n < 20; n++) access(0, 32'h3C0, 0, 1);
    chk("hit_saturated", {28'b0, hit_count}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule
